// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around pipe_stage_reg: upstream valid/ready/data/ctrl, flush, downstream valid/ready/data/ctrl.
// master is the surrounding pipeline side, slave is the register stage itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 80,
    parameter int CTRL_W = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-stage pipeline register (payload + control, control zeroed on bubbles); PIPE_STATS_EN adds stall/bubble counters.
// Latency: DEPTH cycles accept->out_valid when unstalled, 1 entry/cycle throughput.
// Backpressure: stages hold while everything downstream is full and out_ready=0; bubbles collapse; flush empties all stages.
module pipe_stage_reg #(
    parameter int DATA_W = 80,
    parameter int CTRL_W = 11,
    parameter int DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    pipe_stage_reg_if.slave bus
`ifdef PIPE_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] bubble_cnt
`endif
);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  adv;
    logic [DATA_W-1:0] d [DEPTH];
    logic [CTRL_W-1:0] c [DEPTH];

    // A stage may advance if any stage from it to the output is empty, or the output drains.
    always_comb begin
        logic room;
        adv  = '0;
        room = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            room   = room | ~v[k];
            adv[k] = room;
        end
    end

    assign bus.in_ready  = adv[0] & ~bus.flush & ~rst;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.out_ctrl  = v[DEPTH-1] ? c[DEPTH-1] : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              nxt_v;
        logic [DATA_W-1:0] nxt_d;
        logic [CTRL_W-1:0] nxt_c;
        logic              v_q;
        logic [DATA_W-1:0] d_q;
        logic [CTRL_W-1:0] c_q;

        if (k == 0) begin : g_head
            assign nxt_v = bus.in_valid & bus.in_ready;
            assign nxt_d = bus.in_data;
            assign nxt_c = bus.in_ctrl;
        end else begin : g_body
            assign nxt_v = v[k-1];
            assign nxt_d = d[k-1];
            assign nxt_c = c[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
                c_q <= '0;
            end else if (bus.flush) begin
                v_q <= 1'b0;
                c_q <= '0;
            end else if (adv[k]) begin
                v_q <= nxt_v;
                if (nxt_v) begin
                    d_q <= nxt_d;
                end
                c_q <= nxt_v ? nxt_c : '0;
            end
        end

        assign v[k] = v_q;
        assign d[k] = d_q;
        assign c[k] = c_q;
    end

`ifdef PIPE_STATS_EN
    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (!bus.out_valid && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: FIFO-timing scoreboard checked every cycle plus directed vectors with literal expectations.
module tb_pipe_stage_reg;
    localparam int DW    = 80;
    localparam int CW    = 11;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

`ifdef PIPE_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
`endif

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] cf(input logic [DW-1:0] x);
        return x[CW-1:0] ^ 11'h4A5;
    endfunction

    // Model: the stage is a FIFO of capacity DEPTH; an entry shows at the output
    // DEPTH cycles after acceptance, but never before the cycle after its predecessor left.
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            due;
    } ent_t;
    ent_t q[$];
    int          last_pop = -100;
    logic [15:0] es = '0;
    logic [15:0] eb = '0;

    always @(negedge clk) begin
        logic exp_v;
        logic exp_rdy;
        int   due;
        if (rst) begin
            chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
            chk("rst_out_data",  128'(bus.out_data),  128'(0));
            chk("rst_out_ctrl",  128'(bus.out_ctrl),  128'(0));
            chk("rst_in_ready",  128'(bus.in_ready),  128'(0));
`ifdef PIPE_STATS_EN
            chk("rst_stall_cnt",  128'(stall_cnt),  128'(0));
            chk("rst_bubble_cnt", 128'(bubble_cnt), 128'(0));
`endif
            q.delete();
            last_pop = -100;
            es = '0;
            eb = '0;
        end else begin
            exp_v = 1'b0;
            if (q.size() > 0) begin
                due = q[0].due;
                if (last_pop + 1 > due) due = last_pop + 1;
                exp_v = (cyc >= due);
            end
            exp_rdy = !bus.flush && (q.size() < DEPTH || bus.out_ready);
            chk("sb_out_valid", 128'(bus.out_valid), 128'(exp_v));
            chk("sb_in_ready",  128'(bus.in_ready),  128'(exp_rdy));
            if (exp_v) begin
                chk("sb_out_data", 128'(bus.out_data), 128'(q[0].d));
                chk("sb_out_ctrl", 128'(bus.out_ctrl), 128'(q[0].c));
            end else begin
                chk("sb_bubble_ctrl", 128'(bus.out_ctrl), 128'(0));
            end
`ifdef PIPE_STATS_EN
            chk("sb_stall_cnt",  128'(stall_cnt),  128'(es));
            chk("sb_bubble_cnt", 128'(bubble_cnt), 128'(eb));
            if (exp_v && !bus.out_ready && es != 16'hFFFF) es = es + 16'd1;
            if (!exp_v && eb != 16'hFFFF) eb = eb + 16'd1;
`endif
            if (exp_v && bus.out_ready) begin
                void'(q.pop_front());
                last_pop = cyc;
            end
            if (bus.flush) begin
                q.delete();
            end else if (bus.in_valid && exp_rdy) begin
                q.push_back('{d: bus.in_data, c: bus.in_ctrl, due: cyc + DEPTH});
            end
        end
        cyc++;
    end

    task automatic apply(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.in_ctrl   = iv ? cf(id) : 11'h3FF;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 80'h99;
        bus.in_ctrl   = 11'h7FF;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("t1_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("t1_rst_data",  128'(bus.out_data),  128'(0));

        // First entry after reset release appears DEPTH cycles later
        rst = 1'b0;
        apply(1'b1, 80'h11, 1'b1, 1'b0);
        chk("t1_in_ready", 128'(bus.in_ready), 128'(1));
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t1_not_yet", 128'(bus.out_valid), 128'(0));
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t1_lat_valid", 128'(bus.out_valid), 128'(1));
        chk("t1_lat_data",  128'(bus.out_data),  128'(80'h11));
        chk("t1_lat_ctrl",  128'(bus.out_ctrl),  128'(11'h011 ^ 11'h4A5));
        tick();

        // Back-to-back stream 1..10
        for (int c = 0; c < 12; c++) begin
            apply(c < 10, DW'(c + 1), 1'b1, 1'b0);
            if (c >= 2) begin
                chk("t2_stream_valid", 128'(bus.out_valid), 128'(1));
                chk("t2_stream_data",  128'(bus.out_data),  128'(c - 1));
            end
            tick();
        end

        // Fill with A,B then stall five cycles
        apply(1'b1, 80'hA, 1'b0, 1'b0);
        tick();
        apply(1'b1, 80'hB, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 80'hE, 1'b0, 1'b0);
            chk("t3_full_in_ready", 128'(bus.in_ready), 128'(0));
            chk("t3_hold_data",     128'(bus.out_data), 128'(80'hA));
            tick();
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t3_drain_a", 128'(bus.out_data), 128'(80'hA));
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t3_drain_b", 128'(bus.out_data), 128'(80'hB));
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t3_empty", 128'(bus.out_valid), 128'(0));
        tick();

        // Flush with two entries in flight and C offered
        apply(1'b1, 80'hA2, 1'b1, 1'b0);
        tick();
        apply(1'b1, 80'hB2, 1'b1, 1'b0);
        tick();
        apply(1'b1, 80'hC2, 1'b1, 1'b1);
        chk("t4_flush_out_a",    128'(bus.out_data), 128'(80'hA2));
        chk("t4_flush_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        apply(1'b1, 80'hD2, 1'b1, 1'b0);
        chk("t4_post_valid", 128'(bus.out_valid), 128'(0));
        chk("t4_post_ctrl",  128'(bus.out_ctrl),  128'(0));
        chk("t4_d_ready",    128'(bus.in_ready),  128'(1));
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t4_gap", 128'(bus.out_valid), 128'(0));
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t4_d_out", 128'(bus.out_data), 128'(80'hD2));
        tick();

        // Reset in the middle of a stalled transfer
        apply(1'b1, 80'h51, 1'b0, 1'b0);
        tick();
        apply(1'b1, 80'h52, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        apply(1'b1, 80'h53, 1'b1, 1'b0);
        chk("t5_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("t5_rst_data",  128'(bus.out_data),  128'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            chk("t5_nothing_survives", 128'(bus.out_valid), 128'(0));
            tick();
        end

        // Random traffic, backpressure and occasional flush
        for (int i = 0; i < 1000; i++) begin
            apply(1'($urandom_range(0, 1)), {$urandom, $urandom, 16'($urandom)},
                  1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
            tick();
        end
        repeat (4) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

`ifdef PIPE_STATS_EN
        rst = 1'b1;
        apply(1'b0, '0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        repeat (4) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        apply(1'b1, 80'h77, 1'b1, 1'b0);
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        tick();
        repeat (3) begin
            apply(1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        tick();
        apply(1'b0, '0, 1'b1, 1'b0);
        chk("t6_stall_cnt",  128'(stall_cnt),          128'(3));
        chk("t6_bubble_min", 128'(bubble_cnt >= 16'd4), 128'(1));
        apply(1'b1, 80'h88, 1'b0, 1'b0);
        repeat (70000) tick();
        chk("t6_stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
        repeat (4) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
